keypad_matrix_scanner: RTL and testbench

Parametrised matrix-keypad scanner, successor to the 2x2 keypad/LED decoder. Drives one-hot column strobes and samples row returns through a synchroniser. Debounces every key independently and maintains a pressed-key bitmap. Queues key events in a small FIFO read via valid/ready, so LED, UART or game logic upstream can consume keypresses without losing them.

---
 rtl/keypad_matrix_scanner.sv | 194 +++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - matrix keypad scanner with per-key debounce and key event FIFO
// Optional: define KEYPAD_RELEASE_EVT_EN to queue release events as well as presses.
module keypad_matrix_scanner #(
  parameter int NUM_COLS  = 2,
  parameter int NUM_ROWS  = 2,
  parameter int SCAN_DIV  = 1000,
  parameter int DEBOUNCE  = 4,
  parameter int EVT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ROWS-1:0]          row,
  output logic [NUM_COLS-1:0]          col,
  output logic [NUM_ROWS*NUM_COLS-1:0] key_state,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [((NUM_ROWS*NUM_COLS) > 1 ? $clog2(NUM_ROWS*NUM_COLS) : 1)-1:0] evt_code,
  output logic                         evt_press,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int NK = NUM_ROWS * NUM_COLS;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int PW = $clog2(EVT_DEPTH);
  localparam int FW = PW + 1;

  localparam logic [SW-1:0] SLOT_LAST   = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SCAN_DIV - NUM_ROWS - 2);
  localparam logic [SW-1:0] EVAL_START  = SW'(SCAN_DIV - NUM_ROWS);
  localparam logic [CW-1:0] COL_LAST    = CW'(NUM_COLS - 1);
  localparam logic [3:0]    DB          = 4'(DEBOUNCE);
  localparam logic [FW-1:0] FIFO_FULL   = FW'(EVT_DEPTH);

  typedef enum logic [1:0] {ST_SETTLE, ST_CAPTURE, ST_EVAL} state_t;

  state_t               state, state_nxt;
  logic                 capture_en, eval_en;
  logic [NUM_ROWS-1:0]  row_m, row_s, snap;
  logic [SW-1:0]        slot_cnt;
  logic [CW-1:0]        col_idx;
  logic [3:0]           deb_cnt [NK];
  logic [RW-1:0]        eval_row;
  logic [KW-1:0]        eval_key;
  logic                 cur_state, samp;
  logic [3:0]           cnt_inc;
  logic                 flip, push, pop, full, wr_en, drop;
  logic [KW-1:0]        fifo_code [EVT_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [FW-1:0]        fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      col_idx  <= (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  always_comb begin
    col          = '0;
    col[col_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_SETTLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SETTLE:  if (slot_cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_EVAL;
      ST_EVAL:    if (slot_cnt == SLOT_LAST) state_nxt = ST_SETTLE;
      default:    state_nxt = ST_SETTLE;
    endcase
  end

  always_comb begin
    capture_en = 1'b0;
    eval_en    = 1'b0;
    case (state)
      ST_CAPTURE: capture_en = 1'b1;
      ST_EVAL:    eval_en    = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             snap <= '0;
    else if (capture_en) snap <= row_s;
  end

  // One key per EVAL cycle: row = offset into the EVAL window, column = current strobe.
  always_comb begin
    eval_row  = RW'(slot_cnt - EVAL_START);
    eval_key  = KW'(32'(eval_row) * NUM_COLS + 32'(col_idx));
    cur_state = key_state[eval_key];
    samp      = snap[eval_row];
    cnt_inc   = deb_cnt[eval_key] + 4'd1;
    flip      = eval_en && (samp != cur_state) && (cnt_inc == DB);
`ifdef KEYPAD_RELEASE_EVT_EN
    push      = flip;
`else
    push      = flip && !cur_state;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= '0;
      for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
    end else if (eval_en) begin
      if (samp == cur_state) begin
        deb_cnt[eval_key] <= '0;
      end else if (cnt_inc == DB) begin
        deb_cnt[eval_key]   <= '0;
        key_state[eval_key] <= ~cur_state;
      end else begin
        deb_cnt[eval_key] <= cnt_inc;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
  assign full  = (fill == FIFO_FULL);
  assign pop   = evt_valid && evt_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      for (int i = 0; i < EVT_DEPTH; i++) fifo_code[i] <= '0;
    end else begin
      if (wr_en) begin
        fifo_code[wr_ptr] <= eval_key;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: ;
      endcase
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  logic fifo_press [EVT_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < EVT_DEPTH; i++) fifo_press[i] <= 1'b0;
    end else if (wr_en) begin
      fifo_press[wr_ptr] <= ~cur_state;
    end
  end

  assign evt_press = fifo_press[rd_ptr];
`else
  assign evt_press = 1'b1;
`endif

  assign evt_valid = (fill != '0);
  assign evt_code  = fifo_code[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

  localparam int NC = 2, NR = 2, SD = 8, DB = 3, DEPTH = 4, NK = 4;
  localparam int SCAN = NC * SD;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [NK-1:0] key_state;
  logic          evt_valid, evt_ready, evt_press, overflow, ovf_clr;
  logic [1:0]    evt_code;
  logic [NK-1:0] phys;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its column strobe to its row line.
  always_comb begin
    row = '0;
    for (int r = 0; r < NR; r++) row[r] = |(phys[r*NC +: NC] & col);
  end

  keypad_matrix_scanner #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_DIV(SD), .DEBOUNCE(DB), .EVT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_state(key_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // Reference model: time since reset decides column and slot; rows reach the snapshot two edges late.
  int            n;
  logic [NK-1:0] m_ks;
  int            m_cnt [NK];
  logic [NR-1:0] m_snap;
  logic [NK-1:0] p_d1, p_d2;
  int            q_code [$];
  bit            q_press [$];
  bit            m_ovf;
  int            m_slot, m_c, m_r, m_k, m_pk;
  bit            m_pop, m_push, m_pp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_ks = '0; m_snap = '0; p_d1 = '0; p_d2 = '0; m_ovf = 1'b0;
      for (int i = 0; i < NK; i++) m_cnt[i] = 0;
      q_code.delete(); q_press.delete();
    end else begin
      m_slot = n % SD;
      m_c    = (n / SD) % NC;
      m_pop  = (q_code.size() > 0) && evt_ready;
      m_push = 1'b0;
      if (m_slot == SD - NR - 1)
        for (int r = 0; r < NR; r++) m_snap[r] = p_d2[r*NC + m_c];
      if (m_slot >= SD - NR) begin
        m_r = m_slot - (SD - NR);
        m_k = m_r * NC + m_c;
        if (m_snap[m_r] == m_ks[m_k]) m_cnt[m_k] = 0;
        else begin
          m_cnt[m_k]++;
          if (m_cnt[m_k] == DB) begin
            m_ks[m_k]  = ~m_ks[m_k];
            m_cnt[m_k] = 0;
            m_push     = REL_EN || m_ks[m_k];
            m_pk       = m_k;
            m_pp       = m_ks[m_k];
          end
        end
      end
      if (m_pop) begin
        void'(q_code.pop_front());
        void'(q_press.pop_front());
      end
      if (m_push && q_code.size() >= DEPTH) m_ovf = 1'b1;
      else begin
        if (m_push) begin
          q_code.push_back(m_pk);
          q_press.push_back(m_pp);
        end
        if (ovf_clr) m_ovf = 1'b0;
      end
      p_d2 = p_d1;
      p_d1 = phys;
      n++;
    end
  end

  int  exp_code  [4] = '{0, 2, 1, 0};
  bit  exp_press [4] = '{1'b1, 1'b1, 1'b1, !REL_EN};

  task automatic align_scan();
    for (int i = 0; i < SCAN && (n % SCAN) != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; phys = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (col !== 2'b01) $display("FAIL reset_col got %b exp 01", col); else passed++;
    checks++; if (key_state !== 4'b0) $display("FAIL reset_keys got %b exp 0000", key_state); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", evt_valid); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else passed++;
    checks++; if (evt_code !== 2'd0) $display("FAIL reset_code got %0d exp 0", evt_code); else passed++;
    checks++; if (evt_press !== !REL_EN) $display("FAIL reset_press got %b exp %b", evt_press, !REL_EN); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    logic [NC-1:0] ec;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ec = NC'(1) << ((n / SD) % NC);
      checks++; if (col !== ec) $display("FAIL idle_col cyc %0d got %b exp %b", n, col, ec); else passed++;
    end
    checks++; if (key_state !== 4'b0) $display("FAIL idle_keys got %b exp 0000", key_state); else passed++;
    checks++; if (evt_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL idle_flags got valid=%b ovf=%b exp 0 0", evt_valid, overflow); else passed++;
  endtask

  task automatic test_press_key1();
    align_scan();
    phys = 4'b0010;
    repeat (46) @(negedge clk);
    checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b0)
      $display("FAIL press_early got keys=%b valid=%b exp 0000 0", key_state, evt_valid); else passed++;
    @(negedge clk);
    checks++; if (key_state !== 4'b0010) $display("FAIL press_keys got %b exp 0010", key_state); else passed++;
    checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd1 || evt_press !== 1'b1)
      $display("FAIL press_evt got v=%b c=%0d p=%b exp 1 1 1", evt_valid, evt_code, evt_press); else passed++;
    repeat (17) @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) $display("FAIL press_pop got valid=%b exp 0", evt_valid); else passed++;
  endtask

  task automatic test_release_key1();
    align_scan();
    phys = 4'b0000;
    repeat (47) @(negedge clk);
    checks++; if (key_state !== 4'b0000) $display("FAIL release_keys got %b exp 0000", key_state); else passed++;
    checks++; if (evt_valid !== REL_EN) $display("FAIL release_valid got %b exp %b", evt_valid, REL_EN); else passed++;
    if (REL_EN) begin
      checks++; if (evt_code !== 2'd1 || evt_press !== 1'b0)
        $display("FAIL release_evt got c=%0d p=%b exp 1 0", evt_code, evt_press); else passed++;
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) $display("FAIL release_pop got valid=%b exp 0", evt_valid); else passed++;
  endtask

  task automatic test_short_press();
    align_scan();
    phys = 4'b0010;
    repeat (2 * SCAN) @(negedge clk);
    phys = 4'b0000;
    repeat (64) @(negedge clk);
    checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b0)
      $display("FAIL short_press got keys=%b valid=%b exp 0000 0", key_state, evt_valid); else passed++;
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    align_scan(); phys = 4'b0111; repeat (64) @(negedge clk);
    align_scan(); phys = 4'b0100; repeat (64) @(negedge clk);
    if (!REL_EN) begin
      align_scan(); phys = 4'b0111; repeat (64) @(negedge clk);
    end
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else passed++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", overflow); else passed++;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_code !== 2'(exp_code[i]) || evt_press !== exp_press[i])
        $display("FAIL ovf_drain%0d got v=%b c=%0d p=%b exp 1 %0d %b", i, evt_valid, evt_code, evt_press,
                 exp_code[i], exp_press[i]); else passed++;
      @(negedge clk);
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_empty got valid=%b exp 0", evt_valid); else passed++;
  endtask

  task automatic test_same_column_and_reset();
    bit seen;
    phys = 4'b0000; evt_ready = 1'b1;
    repeat (64) @(negedge clk);
    evt_ready = 1'b0;
    checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b0)
      $display("FAIL clean got keys=%b valid=%b exp 0000 0", key_state, evt_valid); else passed++;
    align_scan();
    phys = 4'b0101;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = evt_valid;
    end
    checks++; if (!seen) $display("FAIL pair_timeout got no event exp event within 80 cycles"); else passed++;
    checks++; if (key_state !== 4'b0001 || evt_code !== 2'd0)
      $display("FAIL pair_first got keys=%b c=%0d exp 0001 0", key_state, evt_code); else passed++;
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checks++; if (key_state !== 4'b0101 || evt_valid !== 1'b1 || evt_code !== 2'd2)
      $display("FAIL pair_second got keys=%b v=%b c=%0d exp 0101 1 2", key_state, evt_valid, evt_code); else passed++;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (col !== 2'b01 || key_state !== 4'b0 || evt_valid !== 1'b0 || overflow !== 1'b0 || evt_code !== 2'd0)
      $display("FAIL async_rst got col=%b keys=%b v=%b ovf=%b c=%0d exp 01 0000 0 0 0",
               col, key_state, evt_valid, overflow, evt_code); else passed++;
    phys = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++; if (key_state !== m_ks) $display("FAIL rnd_keys cyc %0d got %b exp %b", n, key_state, m_ks); else passed++;
      checks++; if (evt_valid !== (q_code.size() > 0))
        $display("FAIL rnd_valid cyc %0d got %b exp %b", n, evt_valid, q_code.size() > 0); else passed++;
      checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc %0d got %b exp %b", n, overflow, m_ovf); else passed++;
      if (q_code.size() > 0) begin
        checks++; if (evt_code !== 2'(q_code[0]) || evt_press !== q_press[0])
          $display("FAIL rnd_head cyc %0d got c=%0d p=%b exp %0d %b", n, evt_code, evt_press, q_code[0], q_press[0]);
        else passed++;
      end
      evt_ready = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 47) == 0) phys = NK'($urandom);
    end
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press_key1();
    test_release_key1();
    test_short_press();
    test_overflow();
    test_same_column_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
